adaptive_threshold: RTL and testbench

ADAPTIVE_THRESHOLD -- requirements
Module: adaptive_threshold

---
 rtl/adaptive_threshold_if.sv | 31 +++
 rtl/adaptive_threshold.sv | 122 ++++++++++++
 tb/tb_adaptive_threshold.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/adaptive_threshold_if.sv
// ============================================================================
// adaptive_threshold_if : shared read bus (source + mean) and result write bus
// Revision: 1.0
// ============================================================================
`default_nettype none

interface adaptive_threshold_if #(
    parameter int WIDTH_BITS  = 8,
    parameter int HEIGHT_BITS = 8
);
    logic [WIDTH_BITS-1:0]  oSrcCol;
    logic [HEIGHT_BITS-1:0] oSrcRow;
    logic [7:0]             iSrcData;
    logic [7:0]             iMeanData;
    logic [WIDTH_BITS-1:0]  oResultCol;
    logic [HEIGHT_BITS-1:0] oResultRow;
    logic [7:0]             oResultData;
    logic                   oResultWren;

    modport master (
        output oSrcCol, oSrcRow, oResultCol, oResultRow, oResultData, oResultWren,
        input  iSrcData, iMeanData
    );

    modport slave (
        input  oSrcCol, oSrcRow, oResultCol, oResultRow, oResultData, oResultWren,
        output iSrcData, iMeanData
    );
endinterface

`default_nettype wire

// File: rtl/adaptive_threshold.sv
// ============================================================================
// adaptive_threshold : binarises a frame, pixel = 255 when src > mean - OFFSET
// Revision: 1.0
// ============================================================================
`default_nettype none

module adaptive_threshold #(
    parameter int WIDTH_BITS  = 8,
    parameter int HEIGHT_BITS = 8,
    parameter int WIDTH       = 2**WIDTH_BITS,
    parameter int HEIGHT      = 2**HEIGHT_BITS,
    parameter int OFFSET      = 2
) (
    input  wire logic                             clock,
    input  wire logic                             reset_n,
    input  wire logic                             start,
    adaptive_threshold_if.master                  mem,
    output logic [WIDTH_BITS+HEIGHT_BITS:0]       oFgCount,
    output logic                                  busy,
    output logic                                  finished
);
    localparam int PW = WIDTH_BITS + HEIGHT_BITS;
    localparam int FW = PW + 1;
    localparam logic [PW-1:0]   c_LAST   = PW'(WIDTH * HEIGHT - 1);
    localparam logic signed [9:0] c_OFFSET = 10'(OFFSET);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          state_q;
    logic [PW-1:0]   pos_q;
    logic            valid_q;
    logic [PW-1:0]   addr_q;
    logic            wren_q;
    logic [7:0]      data_q;
    logic [WIDTH_BITS-1:0]  col_q;
    logic [HEIGHT_BITS-1:0] row_q;
    logic [FW-1:0]   fg_q;
    logic            busy_q;
    logic            finished_q;

    // Ten-bit signed compare so a mean below OFFSET yields a negative threshold.
    logic signed [9:0] w_thr;
    logic signed [9:0] w_src;
    logic              w_fg;

    assign w_thr = $signed({2'b00, mem.iMeanData}) - c_OFFSET;
    assign w_src = $signed({2'b00, mem.iSrcData});
    assign w_fg  = (w_src > w_thr);

    assign mem.oSrcCol     = pos_q[WIDTH_BITS-1:0];
    assign mem.oSrcRow     = pos_q[PW-1:WIDTH_BITS];
    assign mem.oResultCol  = col_q;
    assign mem.oResultRow  = row_q;
    assign mem.oResultData = data_q;
    assign mem.oResultWren = wren_q;
    assign oFgCount        = fg_q;
    assign busy            = busy_q;
    assign finished        = finished_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            pos_q      <= '0;
            valid_q    <= 1'b0;
            addr_q     <= '0;
            wren_q     <= 1'b0;
            data_q     <= 8'd0;
            col_q      <= '0;
            row_q      <= '0;
            fg_q       <= '0;
            busy_q     <= 1'b0;
            finished_q <= 1'b0;
        end else begin
            // Read data for the address issued one cycle earlier arrives now.
            valid_q <= (state_q == S_RUN);
            addr_q  <= pos_q;
            wren_q  <= valid_q;
            if (valid_q) begin
                col_q  <= addr_q[WIDTH_BITS-1:0];
                row_q  <= addr_q[PW-1:WIDTH_BITS];
                data_q <= w_fg ? 8'd255 : 8'd0;
                if (w_fg) begin
                    fg_q <= fg_q + FW'(1);
                end
            end

            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q    <= S_RUN;
                        pos_q      <= '0;
                        fg_q       <= '0;
                        finished_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (pos_q == c_LAST) begin
                        state_q <= S_DRAIN;
                    end else begin
                        pos_q <= pos_q + PW'(1);
                    end
                end
                S_DRAIN: begin
                    if (!valid_q) begin
                        state_q    <= S_DONE;
                        busy_q     <= 1'b0;
                        finished_q <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_adaptive_threshold.sv
// ============================================================================
// tb_adaptive_threshold : frame-level model plus directed literal expectations
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_adaptive_threshold;
    localparam int WB  = 2;
    localparam int HB  = 2;
    localparam int N   = 16;
    localparam int OFF = 2;

    logic clock = 1'b0;
    logic reset_n;
    logic start;
    logic [WB+HB:0] fg;
    logic busy;
    logic finished;

    always #5 clock = ~clock;

    adaptive_threshold_if #(.WIDTH_BITS(WB), .HEIGHT_BITS(HB)) mem ();

    adaptive_threshold #(
        .WIDTH_BITS(WB), .HEIGHT_BITS(HB), .OFFSET(OFF)
    ) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .mem(mem),
        .oFgCount(fg), .busy(busy), .finished(finished)
    );

    int src_a [N];
    int mean_a[N];
    int exp_d [N];
    int n_checks = 0;
    int n_fail   = 0;

    // Synchronous-read memories: data for an address appears after the next edge.
    always @(posedge clock) begin
        mem.iSrcData  <= 8'(src_a [{mem.oSrcRow, mem.oSrcCol}]);
        mem.iMeanData <= 8'(mean_a[{mem.oSrcRow, mem.oSrcCol}]);
    end

    task automatic check(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // k = number of rising edges since the accepted start (edge 0); -1 = no frame.
    int k = -1;
    int frame_writes = 0;
    int last_col = 0, last_row = 0, last_data = 0;

    always @(posedge clock) begin
        if (!reset_n) begin
            k = -1;
        end else if (start && !(k >= 0 && k <= N + 1)) begin
            k = 0;
            frame_writes = 0;
            for (int p = 0; p < N; p++)
                exp_d[p] = (src_a[p] > mean_a[p] - OFF) ? 255 : 0;
        end else if (k >= 0 && k < 1000) begin
            k++;
        end
    end

    always @(negedge reset_n) begin
        k = -1;
        last_col = 0; last_row = 0; last_data = 0;
    end

    always @(negedge clock) begin
        int e_fg;
        int lim;
        int p;
        bit e_wren;
        e_wren = (k >= 2 && k <= N + 1);
        e_fg = 0;
        if (k >= 2) begin
            lim = (k - 2 < N - 1) ? k - 2 : N - 1;
            for (int i = 0; i <= lim; i++)
                if (exp_d[i] == 255) e_fg++;
        end
        check("busy", busy, (k >= 0 && k <= N + 1));
        check("finished", finished, (k >= N + 2));
        check("fgcount", fg, e_fg);
        check("wren", mem.oResultWren, e_wren);
        if (mem.oResultWren) frame_writes++;
        if (e_wren) begin
            p = k - 2;
            last_col = p % (1 << WB);
            last_row = p / (1 << WB);
            last_data = exp_d[p];
        end
        check("col", mem.oResultCol, last_col);
        check("row", mem.oResultRow, last_row);
        check("data", mem.oResultData, last_data);
    end

    task automatic fill(input int s, input int m);
        for (int p = 0; p < N; p++) begin
            src_a[p]  = s;
            mean_a[p] = m;
        end
    endtask

    // Leaves the caller at the falling edge just after edge 0.
    task automatic pulse_start;
        @(negedge clock); start = 1'b1;
        @(posedge clock);
        @(negedge clock); start = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        fill(100, 100);
        repeat (3) @(posedge clock);
        #1;
        check("reset_busy", busy, 0);
        check("reset_wren", mem.oResultWren, 0);
        @(negedge clock); #1 reset_n = 1'b1;

        // Equal src/mean: all foreground, finished exactly at edge 18.
        pulse_start();
        repeat (17) @(posedge clock);
        #1 check("fin_edge17", finished, 0);
        @(posedge clock);
        #1;
        check("fin_edge18", finished, 1);
        check("busy_edge18", busy, 0);
        check("fg_100", fg, 16);
        check("writes_100", frame_writes, 16);

        fill(97, 100);
        pulse_start();
        repeat (20) @(posedge clock);
        #1 check("fg_97", fg, 0);

        fill(99, 100);
        pulse_start();
        repeat (20) @(posedge clock);
        #1 check("fg_99", fg, 16);

        // Mixed pattern including negative-threshold pixels.
        for (int p = 0; p < N; p++) begin
            src_a[p]  = (p * 13) % 256;
            mean_a[p] = 200 - p * 7;
        end
        src_a[0] = 0;   mean_a[0] = 1;
        src_a[1] = 0;   mean_a[1] = 0;
        src_a[2] = 98;  mean_a[2] = 100;
        src_a[3] = 99;  mean_a[3] = 100;
        pulse_start();
        repeat (2) @(posedge clock);
        #1;
        check("px0_wren", mem.oResultWren, 1);
        check("px0_data", mem.oResultData, 255);
        @(posedge clock); #1 check("px1_data", mem.oResultData, 255);
        @(posedge clock); #1 check("px2_data", mem.oResultData, 0);
        @(posedge clock); #1 check("px3_data", mem.oResultData, 255);
        repeat (16) @(posedge clock);

        // Second start inside a running frame is ignored.
        fill(100, 100);
        pulse_start();
        repeat (4) @(posedge clock);
        @(negedge clock); start = 1'b1;
        @(posedge clock);
        @(negedge clock); start = 1'b0;
        repeat (20) @(posedge clock);
        #1;
        check("restart_writes", frame_writes, 16);
        check("restart_fg", fg, 16);

        // Reset after the 6th write aborts the frame.
        pulse_start();
        repeat (7) @(posedge clock);
        @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        check("abort_wren", mem.oResultWren, 0);
        check("abort_busy", busy, 0);
        check("abort_fg", fg, 0);
        repeat (2) @(posedge clock);
        @(negedge clock); #1 reset_n = 1'b1;
        repeat (3) @(posedge clock);
        #1 check("abort_idle_wren", mem.oResultWren, 0);
        pulse_start();
        repeat (20) @(posedge clock);
        #1;
        check("after_abort_writes", frame_writes, 16);
        check("after_abort_fg", fg, 16);

        // Start from DONE clears finished and the count at edge 0.
        pulse_start();
        #1;
        check("done_restart_fin", finished, 0);
        check("done_restart_fg", fg, 0);
        repeat (20) @(posedge clock);
        #1;
        check("second_writes", frame_writes, 16);
        check("second_fg", fg, 16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
